// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: track/hold, MSB-first binary search on a synchronised comparator.
// Latency start->done is 1+SAMPLE_CYCLES+WIDTH*(SETTLE_CYCLES+1); start is ignored (not queued) while busy.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp_in,
  output logic             sample,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0]       SAMPLE_LOAD = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] MSB_MASK    = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || WIDTH > 12) begin : g_bad_width
    $error("sar_adc_ctrl: WIDTH out of range");
  end
  if (SAMPLE_CYCLES < 1 || SAMPLE_CYCLES > 255) begin : g_bad_sample
    $error("sar_adc_ctrl: SAMPLE_CYCLES out of range");
  end
  if (SETTLE_CYCLES < 2 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("sar_adc_ctrl: SETTLE_CYCLES out of range");
  end

  state_t           state;
  logic [1:0]       sync_q;
  logic             cmp_s;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] trial_nx;

  assign cmp_s = sync_q[1];

  // One-hot bit_mask marks the bit under trial; the decision is a plain set or clear.
  always_comb begin
    trial_nx = cmp_s ? (trial | bit_mask) : (trial & ~bit_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sync_q   <= '0;
      cnt      <= '0;
      trial    <= '0;
      bit_mask <= '0;
      sample   <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      sync_q <= {sync_q[0], cmp_in};
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state  <= ST_SAMPLE;
            sample <= 1'b1;
            busy   <= 1'b1;
            cnt    <= SAMPLE_LOAD;
            trial  <= '0;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state  <= ST_IDLE;
            sample <= 1'b0;
            busy   <= 1'b0;
            trial  <= '0;
          end else if (cnt == 8'd0) begin
            state    <= ST_CONVERT;
            sample   <= 1'b0;
            cnt      <= SETTLE_LOAD;
            bit_mask <= MSB_MASK;
            dac_code <= MSB_MASK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_CONVERT: begin
          if (abort) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            dac_code <= '0;
            trial    <= '0;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (bit_mask[0]) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            dac_code <= '0;
            done     <= 1'b1;
            trial    <= trial_nx;
            result   <= trial_nx;
          end else begin
            // Next phase presents the resolved bits plus the next trial bit.
            trial    <= trial_nx;
            bit_mask <= bit_mask >> 1;
            dac_code <= trial_nx | (bit_mask >> 1);
            cnt      <= SETTLE_LOAD;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
